cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates completing functional units (ALU, mult, load, branch) onto the single completion broadcast bus.
- The bus drives the ROB complete port (complete_en/complete_idx) and the reservation-station/map-table tag wakeup.
- Each FU has a one-entry holding buffer; a round-robin pointer selects one buffered result per cycle; the bus output is registered.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- ROB_IDX_W, 5, ROB index width; equals $clog2(`ROB_SZ).
- PREG_W, 6, physical register tag width.
- XLEN, 32, result data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash (mispredict): discard all buffered and outgoing results.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_ready  out  NUM_FU  per-FU buffer can accept this cycle.
- fu_rob_idx  in  NUM_FU*ROB_IDX_W  per-FU ROB index; FU i occupies slice [i*ROB_IDX_W +: ROB_IDX_W].
- fu_tag  in  NUM_FU*PREG_W  per-FU destination physical tag; same slicing.
- fu_value  in  NUM_FU*XLEN  per-FU result value; same slicing.
- cdb_valid  out  1  broadcast valid; feeds ROB complete_en.
- cdb_rob_idx  out  ROB_IDX_W  broadcast ROB index; feeds complete_idx.
- cdb_tag  out  PREG_W  broadcast tag.
- cdb_value  out  XLEN  broadcast value.
- cdb_src  out  $clog2(NUM_FU)  index of the winning FU (debug/perf).

Behaviour:
- Reset (async, active-high):
  - All buf_valid cleared; rr_ptr = 0.
  - cdb_valid = 0; cdb_rob_idx, cdb_tag, cdb_value and cdb_src = 0.
  - fu_ready = all ones once reset deasserts.
  - Reset mid-operation drops every held result.
- Buffers:
  - Per FU: buf_valid, buf_rob_idx, buf_tag, buf_value.
  - fu_ready[i] = !buf_valid[i] || grant[i] (combinational; same-cycle refill of a buffer that is being drained).
  - Capture at a clock edge when fu_valid[i] && fu_ready[i].
  - fu_valid with fu_ready low is ignored; the FU must hold its data.
- Arbitration (combinational, each cycle):
  - Candidates are FUs with buf_valid.
  - Winner is the first candidate found searching i = rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - grant is one-hot or zero.
  - Freshly arriving fu_valid is not a candidate in its arrival cycle; there is no bypass.
- On the edge when a grant is made:
  - cdb_* registers load the winner's buffer; cdb_valid = 1; cdb_src = winner.
  - Winner's buf_valid clears, unless the same edge refills it.
  - rr_ptr = (winner + 1) mod NUM_FU; wrap is explicit for non-power-of-two NUM_FU.
- On an edge with no grant: cdb_valid = 0, other cdb_* hold their values, rr_ptr holds.
- Latency and throughput:
  - Handshake sampled at edge E0 → earliest cdb_valid in the cycle after edge E0+1, i.e. 2 cycles.
  - Sustained throughput is one broadcast per cycle.
  - Each FU sustains one result per cycle when it is granted every cycle.
- Fairness: a buffered FU is granted within NUM_FU cycles of becoming a candidate.
- Flush (sampled at an edge):
  - All buf_valid = 0; cdb_valid = 0; rr_ptr unchanged.
  - Handshakes in the flush cycle are discarded.
  - fu_ready follows the normal rule in the flush cycle.
  - A grant coincident with flush is suppressed.
- No duplicate or lost results: every accepted handshake not flushed produces exactly one cdb_valid cycle carrying its exact idx/tag/value.
- Output has no backpressure: the ROB and RS always accept cdb_valid.

Test Plan:
- Single FU2, rob_idx=7, tag=0x15, value=0xDEADBEEF in cycle 1, rr_ptr=0 → cdb_valid in cycle 3 with those fields, cdb_src=2, rr_ptr=3, fu_ready[2] high throughout.
- All 4 FUs valid in the same cycle after reset → grants in order 0,1,2,3 on consecutive cycles, cdb_valid high for 4 cycles, then 0.
- FU0 streams every cycle while FU1 holds a buffered result → FU1 granted within 2 cycles.
  - Grants then alternate 0,1,0,1.
  - fu_ready[0] drops while FU0's buffer is waiting.
- Buffer full and not granted: FU3 valid with fu_ready[3]=0 for 3 cycles, data changing → ignored.
  - Only the buffered result broadcasts.
  - The next held value is accepted once ready.
- Flush asserted with FU1 and FU2 buffered and cdb_valid=1 → next cycle cdb_valid=0, buffers empty, no broadcast of either; rr_ptr value retained.
- Async reset pulse mid-stream, between edges → cdb_valid and fu_ready state clear immediately; after release, a new FU0 result broadcasts with cdb_src=0.
- Random scoreboard, NUM_FU=3, 10k cycles → every accepted result appears exactly once, rr_ptr wraps 2→0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges completing functional units onto the single completion
// broadcast bus (ROB complete port + RS/map-table tag wakeup).
//   clock, reset                   clock, async active-high reset
//   flush                          squash every buffered and outgoing result
//   fu_valid / fu_ready            per-FU result handshake (ready is combinational)
//   fu_rob_idx, fu_tag, fu_value   per-FU payload, FU i at [i*W +: W]
//   cdb_valid, cdb_rob_idx,
//   cdb_tag, cdb_value             registered broadcast
//   cdb_src                        index of the FU that won the broadcast
// Each FU owns a one-entry holding buffer (cdb_fu_buf). A round-robin pointer
// picks one full buffer per cycle. The winner's buffer can refill on the same
// edge it drains, so a single FU that keeps winning streams at full rate.

// One-entry holding buffer for a single FU.
//   in_*     FU payload and valid;  grant  this buffer wins arbitration now
//   ready    buffer can take a result this cycle
//   buf_*    held result
module cdb_fu_buf #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PREG_W-1:0]    in_tag,
  input  logic [XLEN-1:0]      in_value,
  input  logic                 grant,
  output logic                 ready,
  output logic                 buf_valid,
  output logic [ROB_IDX_W-1:0] buf_rob_idx,
  output logic [PREG_W-1:0]    buf_tag,
  output logic [XLEN-1:0]      buf_value
);
  // A draining buffer may take the next result on the same edge.
  assign ready = !buf_valid || grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid   <= 1'b0;
      buf_rob_idx <= '0;
      buf_tag     <= '0;
      buf_value   <= '0;
    end else if (flush) begin
      // Handshakes in the flush cycle are dropped as well.
      buf_valid <= 1'b0;
    end else if (in_valid && ready) begin
      buf_valid   <= 1'b1;
      buf_rob_idx <= in_rob_idx;
      buf_tag     <= in_tag;
      buf_value   <= in_value;
    end else if (grant) begin
      buf_valid <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6,
  parameter int XLEN      = 32,
  localparam int SRC_W    = $clog2(NUM_FU)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*PREG_W-1:0]    fu_tag,
  input  logic [NUM_FU*XLEN-1:0]      fu_value,
  output logic                        cdb_valid,
  output logic [ROB_IDX_W-1:0]        cdb_rob_idx,
  output logic [PREG_W-1:0]           cdb_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic [SRC_W-1:0]            cdb_src
);
  logic [NUM_FU-1:0]                 buf_valid;
  logic [NUM_FU-1:0]                 grant;
  logic [NUM_FU-1:0][ROB_IDX_W-1:0]  buf_rob_idx;
  logic [NUM_FU-1:0][PREG_W-1:0]     buf_tag;
  logic [NUM_FU-1:0][XLEN-1:0]       buf_value;
  logic [SRC_W-1:0]                  rr_ptr;
  logic [SRC_W-1:0]                  win;
  logic [SRC_W-1:0]                  rr_next;
  logic                              any_grant;
  int                                cand;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    cdb_fu_buf #(
      .ROB_IDX_W(ROB_IDX_W),
      .PREG_W   (PREG_W),
      .XLEN     (XLEN)
    ) u_buf (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (fu_valid[i]),
      .in_rob_idx (fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]),
      .in_tag     (fu_tag[i*PREG_W +: PREG_W]),
      .in_value   (fu_value[i*XLEN +: XLEN]),
      .grant      (grant[i]),
      .ready      (fu_ready[i]),
      .buf_valid  (buf_valid[i]),
      .buf_rob_idx(buf_rob_idx[i]),
      .buf_tag    (buf_tag[i]),
      .buf_value  (buf_value[i])
    );
  end

  // Round-robin search starting at rr_ptr. Only buffered results compete;
  // a result arriving this cycle waits for the next one.
  always_comb begin
    grant     = '0;
    win       = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_FU) cand = cand - NUM_FU;
      if (!any_grant && buf_valid[cand]) begin
        any_grant   = 1'b1;
        win         = SRC_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // Explicit wrap so non-power-of-two NUM_FU never points past the last FU.
  assign rr_next = (win == SRC_W'(NUM_FU - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_src     <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      // Grant suppressed: pointer stays, nothing broadcasts.
      cdb_valid <= 1'b0;
    end else if (any_grant) begin
      cdb_valid   <= 1'b1;
      cdb_rob_idx <= buf_rob_idx[win];
      cdb_tag     <= buf_tag[win];
      cdb_value   <= buf_value[win];
      cdb_src     <= win;
      rr_ptr      <= rr_next;
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios on a 4-FU instance, then a
// randomized run on a 3-FU instance against a cycle-level reference model
// plus an exactly-once scoreboard keyed by unique result values.
module tb_cdb_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // 4-FU instance
  logic        a_flush;
  logic [3:0]  a_valid, a_ready;
  logic [19:0] a_rob;
  logic [23:0] a_tag;
  logic [127:0] a_val;
  logic        a_cv;
  logic [4:0]  a_crob;
  logic [5:0]  a_ctag;
  logic [31:0] a_cval;
  logic [1:0]  a_src;

  // 3-FU instance
  logic        b_flush;
  logic [2:0]  b_valid, b_ready;
  logic [14:0] b_rob;
  logic [17:0] b_tag;
  logic [95:0] b_val;
  logic        b_cv;
  logic [4:0]  b_crob;
  logic [5:0]  b_ctag;
  logic [31:0] b_cval;
  logic [1:0]  b_src;

  cdb_arbiter #(.NUM_FU(4)) u_dut4 (
    .clock(clock), .reset(reset), .flush(a_flush),
    .fu_valid(a_valid), .fu_ready(a_ready),
    .fu_rob_idx(a_rob), .fu_tag(a_tag), .fu_value(a_val),
    .cdb_valid(a_cv), .cdb_rob_idx(a_crob), .cdb_tag(a_ctag),
    .cdb_value(a_cval), .cdb_src(a_src)
  );

  cdb_arbiter #(.NUM_FU(3)) u_dut3 (
    .clock(clock), .reset(reset), .flush(b_flush),
    .fu_valid(b_valid), .fu_ready(b_ready),
    .fu_rob_idx(b_rob), .fu_tag(b_tag), .fu_value(b_val),
    .cdb_valid(b_cv), .cdb_rob_idx(b_crob), .cdb_tag(b_ctag),
    .cdb_value(b_cval), .cdb_src(b_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic seta(input int i, input logic [4:0] r, input logic [5:0] t, input logic [31:0] v);
    a_rob[i*5 +: 5]  = r;
    a_tag[i*6 +: 6]  = t;
    a_val[i*32 +: 32] = v;
  endtask

  // Reset pulse placed between clock edges.
  task automatic rst_pulse();
    @(negedge clock);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  // Reference model state for the 3-FU instance
  bit          mbv[3];
  logic [4:0]  mrob[3];
  logic [5:0]  mtag[3];
  logic [31:0] mval[3];
  int          mptr;
  bit          m_cv;
  logic [4:0]  m_crob;
  logic [5:0]  m_ctag;
  logic [31:0] m_cval;
  int          m_csrc;
  bit          pend[3];
  bit          sb[bit [31:0]];
  int unsigned uid;
  int          wraps;

  initial begin
    logic [3:0] pr;
    int ia, ib, k, w;
    bit fl;
    logic [2:0] er;

    a_flush = 0; a_valid = 0; a_rob = 0; a_tag = 0; a_val = 0;
    b_flush = 0; b_valid = 0; b_rob = 0; b_tag = 0; b_val = 0;
    #12 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_cv", a_cv, 0);
    chk("rst_src", a_src, 0);
    chk("rst_rob", a_crob, 0);
    chk("rst_tag", a_ctag, 0);
    chk("rst_val", a_cval, 0);
    chk("rst_rdy4", a_ready, 4'hF);
    chk("rst_rdy3", b_ready, 3'h7);

    // Single FU2 result, two-cycle latency
    seta(2, 5'd7, 6'h15, 32'hDEADBEEF);
    a_valid = 4'b0100;
    @(negedge clock);
    chk("t1_rdy2_a", a_ready[2], 1);
    a_valid = 0;
    @(negedge clock);
    chk("t1_cv", a_cv, 1);
    chk("t1_rob", a_crob, 7);
    chk("t1_tag", a_ctag, 6'h15);
    chk("t1_val", a_cval, 32'hDEADBEEF);
    chk("t1_src", a_src, 2);
    chk("t1_rdy2_b", a_ready[2], 1);
    // rr_ptr now 3: with FU0 and FU3 both buffered, FU3 wins first
    seta(0, 5'd1, 6'd1, 32'h0000_0A00);
    seta(3, 5'd2, 6'd2, 32'h0000_0A03);
    a_valid = 4'b1001;
    @(negedge clock);
    chk("t1_cv_drop", a_cv, 0);
    chk("t1_src_hold", a_src, 2);
    a_valid = 0;
    @(negedge clock);
    chk("t1_ptr3_src", a_src, 3);
    @(negedge clock);
    chk("t1_wrap_src", a_src, 0);
    chk("t1_wrap_val", a_cval, 32'h0000_0A00);

    // All four FUs at once after reset
    rst_pulse();
    @(negedge clock);
    for (int i = 0; i < 4; i++) seta(i, 5'(i + 1), 6'(i + 8), 32'h100 + i);
    a_valid = 4'hF;
    @(negedge clock);
    a_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t2_cv", a_cv, 1);
      chk("t2_src", a_src, i);
      chk("t2_val", a_cval, 32'h100 + i);
      chk("t2_rob", a_crob, i + 1);
    end
    @(negedge clock);
    chk("t2_cv_end", a_cv, 0);

    // FU0 and FU1 both stream; grants alternate
    ia = 0; ib = 0;
    seta(0, 5'd0, 6'd0, 32'hA000_0000);
    seta(1, 5'd0, 6'd0, 32'hB000_0000);
    a_valid = 4'b0011;
    pr = a_ready;
    for (int c = 1; c < 10; c++) begin
      @(negedge clock);
      if (pr[0]) ia++;
      if (pr[1]) ib++;
      if (c >= 2) begin
        k = c - 2;
        chk("t3_cv", a_cv, 1);
        chk("t3_src", a_src, k % 2);
        chk("t3_val", a_cval, (k % 2) ? 32'hB000_0000 + k / 2 : 32'hA000_0000 + k / 2);
        chk("t3_rdy0", a_ready[0], (k % 2) == 1);
      end
      pr = a_ready;
      seta(0, 5'(ia), 6'd0, 32'hA000_0000 + ia);
      seta(1, 5'(ib), 6'd0, 32'hB000_0000 + ib);
    end
    a_valid = 0;
    repeat (3) @(negedge clock);

    // FU3 presents changing data while its buffer is full and not granted
    rst_pulse();
    @(negedge clock);
    for (int i = 0; i < 3; i++) seta(i, 5'(i), 6'(i), 32'h400 + i);
    seta(3, 5'd3, 6'd3, 32'hC000_0000);
    a_valid = 4'hF;
    for (int c = 1; c < 5; c++) begin
      @(negedge clock);
      a_valid = 4'b1000;
      chk("t4_rdy3", a_ready[3], c == 4);
      if (c >= 2) begin
        chk("t4_src", a_src, c - 2);
        chk("t4_val", a_cval, 32'h400 + c - 2);
      end
      seta(3, 5'(c), 6'(c), 32'hC000_0000 + c);
    end
    @(negedge clock);
    a_valid = 0;
    chk("t4_src3", a_src, 3);
    chk("t4_x0", a_cval, 32'hC000_0000);
    @(negedge clock);
    chk("t4_cv_x4", a_cv, 1);
    chk("t4_x4", a_cval, 32'hC000_0004);
    @(negedge clock);
    chk("t4_cv_end", a_cv, 0);

    // Flush with FU1/FU2 buffered and a broadcast in flight
    for (int i = 0; i < 3; i++) seta(i, 5'(i), 6'(i), 32'h500 + i);
    a_valid = 4'b0111;
    @(negedge clock);
    a_valid = 0;
    @(negedge clock);
    chk("t5_pre_cv", a_cv, 1);
    chk("t5_pre_src", a_src, 0);
    a_flush = 1;
    seta(3, 5'd9, 6'd9, 32'h5FF);
    a_valid = 4'b1000;
    @(negedge clock);
    a_flush = 0;
    chk("t5_cv", a_cv, 0);
    chk("t5_empty", a_ready, 4'hF);
    seta(0, 5'd10, 6'd10, 32'h5A0);
    seta(1, 5'd11, 6'd11, 32'h5A1);
    a_valid = 4'b0011;
    @(negedge clock);
    a_valid = 0;
    chk("t5_cv2", a_cv, 0);
    @(negedge clock);
    chk("t5_ptr_src", a_src, 1);
    chk("t5_ptr_val", a_cval, 32'h5A1);
    @(negedge clock);
    chk("t5_src0", a_src, 0);
    chk("t5_val0", a_cval, 32'h5A0);
    @(negedge clock);
    chk("t5_cv_end", a_cv, 0);

    // Async reset mid-stream
    seta(0, 5'd1, 6'd1, 32'h600);
    seta(1, 5'd2, 6'd2, 32'h601);
    a_valid = 4'b0011;
    @(negedge clock);
    a_valid = 0;
    @(negedge clock);
    chk("t6_pre_cv", a_cv, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_cv", a_cv, 0);
    chk("t6_async_rdy", a_ready, 4'hF);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("t6_dropped", a_cv, 0);
    seta(0, 5'd3, 6'd3, 32'h610);
    seta(1, 5'd4, 6'd4, 32'h611);
    a_valid = 4'b0011;
    @(negedge clock);
    a_valid = 0;
    chk("t6_cv_wait", a_cv, 0);
    @(negedge clock);
    chk("t6_src0", a_src, 0);
    chk("t6_val0", a_cval, 32'h610);
    @(negedge clock);
    chk("t6_src1", a_src, 1);
    @(negedge clock);
    chk("t6_cv_end", a_cv, 0);

    // Randomized run on the 3-FU instance
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      mbv[i] = 0; mrob[i] = 0; mtag[i] = 0; mval[i] = 0; pend[i] = 0;
    end
    mptr = 0; m_cv = 0; m_crob = 0; m_ctag = 0; m_cval = 0; m_csrc = 0;
    uid = 1; wraps = 0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clock);
      chk("r_cv", b_cv, m_cv);
      chk("r_src", b_src, m_csrc);
      chk("r_rob", b_crob, m_crob);
      chk("r_tag", b_ctag, m_ctag);
      chk("r_val", b_cval, m_cval);
      if (b_cv) begin
        chk("r_sb_hit", sb.exists(b_cval), 1);
        if (sb.exists(b_cval)) sb.delete(b_cval);
      end

      fl = (cyc < 10000) && ($urandom_range(0, 63) == 0);
      b_flush = fl;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if (cyc < 10000 && $urandom_range(0, 3) != 0) begin
            b_valid[i] = 1'b1;
            b_rob[i*5 +: 5]   = 5'($urandom);
            b_tag[i*6 +: 6]   = 6'($urandom);
            b_val[i*32 +: 32] = uid;
            uid++;
          end else begin
            b_valid[i] = 1'b0;
          end
        end
      end

      // Winner: first buffered FU at or after the pointer, modulo 3
      w = -1;
      for (int j = 0; j < 3; j++)
        if (w < 0 && mbv[(mptr + j) % 3]) w = (mptr + j) % 3;
      for (int i = 0; i < 3; i++) er[i] = !mbv[i] || (w == i);
      #1;
      chk("r_rdy", b_ready, er);

      if (fl) begin
        for (int i = 0; i < 3; i++) begin
          if (mbv[i]) sb.delete(mval[i]);
          mbv[i] = 0;
        end
        m_cv = 0;
      end else begin
        if (w >= 0) begin
          m_cv = 1; m_crob = mrob[w]; m_ctag = mtag[w]; m_cval = mval[w]; m_csrc = w;
          mbv[w] = 0;
          if (mptr == 2 && w == 2) wraps++;
          mptr = (w + 1) % 3;
        end else begin
          m_cv = 0;
        end
        for (int i = 0; i < 3; i++) begin
          if (b_valid[i] && er[i]) begin
            mbv[i]  = 1;
            mrob[i] = b_rob[i*5 +: 5];
            mtag[i] = b_tag[i*6 +: 6];
            mval[i] = b_val[i*32 +: 32];
            sb[mval[i]] = 1'b1;
          end
        end
      end
      for (int i = 0; i < 3; i++) pend[i] = b_valid[i] && !er[i];
    end
    b_valid = 0;
    b_flush = 0;
    chk("r_sb_empty", sb.num(), 0);
    chk("r_wrap_seen", wraps > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
